// File: rtl/rptr_empty_sync.sv
// -----------------------------------------------------------------------------
// rptr_empty_sync
//   Read-side controller of an asynchronous FIFO. Everything here runs in the
//   read clock domain.
//     * Brings the Gray-coded write pointer into rclk through a plain 2-FF chain.
//     * Keeps the binary and Gray read pointers and drives the RAM read address.
//     * Produces registered empty, almost-empty, occupancy and underflow flags.
//
// Parameters
//   ADDRSIZEL  FIFO address width; depth = 2**ADDRSIZEL; pointers are ADDRSIZEL+1
//   AEMPTY_TH  ralmost_empty asserts when occupancy <= AEMPTY_TH
//
// Ports
//   rclk          in   read clock
//   rrst_n        in   asynchronous active-low reset
//   rinc          in   read request; pops one entry when rempty==0
//   wptr          in   Gray write pointer from the write domain (asynchronous)
//   rptr          out  registered Gray read pointer, to the write-side sync
//   raddr         out  RAM read address (low bits of the binary read pointer)
//   rempty        out  FIFO empty, registered
//   ralmost_empty out  occupancy <= AEMPTY_TH, registered
//   rcount        out  occupancy as seen from the read domain, registered
//   runderflow    out  one-cycle pulse for a read request while empty
// -----------------------------------------------------------------------------
module rptr_empty_sync #(
   parameter int unsigned ADDRSIZEL = 4,
   parameter int unsigned AEMPTY_TH = 2
) (
   input  logic                 rclk,
   input  logic                 rrst_n,
   input  logic                 rinc,
   input  logic [ADDRSIZEL:0]   wptr,
   output logic [ADDRSIZEL:0]   rptr,
   output logic [ADDRSIZEL-1:0] raddr,
   output logic                 rempty,
   output logic                 ralmost_empty,
   output logic [ADDRSIZEL:0]   rcount,
   output logic                 runderflow
);

   localparam int unsigned PW = ADDRSIZEL + 1;
   localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

   // --------------------------------------------------------------------------
   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   // --------------------------------------------------------------------------
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [PW-1:0] rq1_wptr_q, rq2_wptr_q;
   logic [PW-1:0] rbin_q,     rbin_d;
   logic [PW-1:0] rptr_q,     rptr_d;
   logic          rempty_q,   rempty_d;
   logic          raempty_q,  raempty_d;
   logic [PW-1:0] rcount_q,   rcount_d;
   logic          runder_q,   runder_d;

   // --------------------------------------------------------------------------
   // Write-pointer synchronizer. Kept free of any logic between the flops so
   // only a single Gray bit can be in flight at a time.
   // --------------------------------------------------------------------------
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rq1_wptr_q <= '0;
         rq2_wptr_q <= '0;
      end else begin
         rq1_wptr_q <= wptr;
         rq2_wptr_q <= rq1_wptr_q;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   logic          pop;
   logic [PW-1:0] wbin_s;
   logic [PW-1:0] occ;

   always_comb begin
      pop       = rinc & ~rempty_q;
      // A request while empty is dropped: the pointers simply hold.
      rbin_d    = rbin_q + {{(PW-1){1'b0}}, pop};
      rptr_d    = bin2gray(rbin_d);
      wbin_s    = gray2bin(rq2_wptr_q);
      // Modular difference covers pointer wrap; range is 0..2**ADDRSIZEL.
      occ       = wbin_s - rbin_d;
      // Empty is decided in Gray against the synchronized pointer only, so it
      // can be late (pessimistic) but never early.
      rempty_d  = (rptr_d == rq2_wptr_q);
      rcount_d  = occ;
      raempty_d = (occ <= AE_TH);
      runder_d  = rinc & rempty_q;
   end

   // --------------------------------------------------------------------------
   // Pointer and flag registers
   // --------------------------------------------------------------------------
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin_q    <= '0;
         rptr_q    <= '0;
         rempty_q  <= 1'b1;
         raempty_q <= 1'b1;
         rcount_q  <= '0;
         runder_q  <= 1'b0;
      end else begin
         rbin_q    <= rbin_d;
         rptr_q    <= rptr_d;
         rempty_q  <= rempty_d;
         raempty_q <= raempty_d;
         rcount_q  <= rcount_d;
         runder_q  <= runder_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign rptr          = rptr_q;
   assign raddr         = rbin_q[ADDRSIZEL-1:0];
   assign rempty        = rempty_q;
   assign ralmost_empty = raempty_q;
   assign rcount        = rcount_q;
   assign runderflow    = runder_q;

endmodule

// File: tb/tb_rptr_empty_sync.sv
module tb_rptr_empty_sync;
   localparam int AW = 4;
   localparam int PW = AW + 1;
   localparam int TH = 2;

   logic          rclk = 1'b0;
   logic          rrst_n;
   logic          rinc;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [AW-1:0] raddr;
   logic          rempty;
   logic          ralmost_empty;
   logic [PW-1:0] rcount;
   logic          runderflow;

   int errs   = 0;
   int checks = 0;

   // Scoreboard of RAM addresses written, in order; popped on each read.
   logic [AW-1:0] sb_q[$];

   rptr_empty_sync #(.ADDRSIZEL(AW), .AEMPTY_TH(TH)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .wptr(wptr),
      .rptr(rptr), .raddr(raddr), .rempty(rempty),
      .ralmost_empty(ralmost_empty), .rcount(rcount), .runderflow(runderflow)
   );

   always #5 rclk = ~rclk;

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic tick;
      @(posedge rclk);
      #1;
   endtask

   task automatic do_reset;
      rinc = 1'b0;
      wptr = '0;
      @(negedge rclk);
      rrst_n = 1'b0;
      @(negedge rclk);
      rrst_n = 1'b1;
      sb_q.delete();
      tick();
   endtask

   // Reset asserted mid-cycle with state loaded: outputs clear without a clock.
   task automatic test_reset;
      do_reset();
      wptr = gray(5'd5);
      repeat (3) tick();
      rinc = 1'b1;
      tick();
      tick();
      rinc = 1'b0;
      checks++; if (rptr !== gray(5'd2)) begin errs++; $display("FAIL pre_reset_rptr got=%b exp=%b", rptr, gray(5'd2)); end
      checks++; if (rcount !== 5'd3) begin errs++; $display("FAIL pre_reset_rcount got=%0d exp=3", rcount); end
      rinc = 1'b1;
      #2;
      rrst_n = 1'b0;
      #1;
      checks++; if (rempty !== 1'b1) begin errs++; $display("FAIL rst_rempty got=%b exp=1", rempty); end
      checks++; if (ralmost_empty !== 1'b1) begin errs++; $display("FAIL rst_raempty got=%b exp=1", ralmost_empty); end
      checks++; if (rptr !== '0) begin errs++; $display("FAIL rst_rptr got=%b exp=0", rptr); end
      checks++; if (raddr !== '0) begin errs++; $display("FAIL rst_raddr got=%0d exp=0", raddr); end
      checks++; if (rcount !== '0) begin errs++; $display("FAIL rst_rcount got=%0d exp=0", rcount); end
      checks++; if (runderflow !== 1'b0) begin errs++; $display("FAIL rst_runder got=%b exp=0", runderflow); end
      rinc = 1'b0;
      wptr = '0;
      tick();
      checks++; if (rempty !== 1'b1 || rptr !== '0) begin errs++; $display("FAIL rst_hold got=%b/%b exp=1/0", rempty, rptr); end
      @(negedge rclk);
      rrst_n = 1'b1;
      tick();
   endtask

   // One write becomes visible exactly two edges after it is sampled.
   task automatic test_latency;
      do_reset();
      wptr = 5'b00001;
      tick(); // edge N
      checks++; if (rempty !== 1'b1) begin errs++; $display("FAIL lat_N_rempty got=%b exp=1", rempty); end
      tick(); // edge N+1
      checks++; if (rempty !== 1'b1 || rcount !== 5'd0) begin errs++; $display("FAIL lat_N1 got=%b/%0d exp=1/0", rempty, rcount); end
      tick(); // edge N+2
      checks++; if (rempty !== 1'b0) begin errs++; $display("FAIL lat_N2_rempty got=%b exp=0", rempty); end
      checks++; if (rcount !== 5'd1) begin errs++; $display("FAIL lat_N2_rcount got=%0d exp=1", rcount); end
      checks++; if (ralmost_empty !== 1'b1) begin errs++; $display("FAIL lat_N2_raempty got=%b exp=1", ralmost_empty); end
   endtask

   task automatic test_underflow;
      do_reset();
      rinc = 1'b1;
      tick();
      rinc = 1'b0;
      checks++; if (runderflow !== 1'b1) begin errs++; $display("FAIL uf_pulse got=%b exp=1", runderflow); end
      checks++; if (rptr !== '0 || raddr !== '0) begin errs++; $display("FAIL uf_ptr got=%b/%0d exp=0/0", rptr, raddr); end
      tick();
      checks++; if (runderflow !== 1'b0) begin errs++; $display("FAIL uf_one_cycle got=%b exp=0", runderflow); end
      checks++; if (rempty !== 1'b1) begin errs++; $display("FAIL uf_rempty got=%b exp=1", rempty); end
   endtask

   // Fill to 16 in one step, then drain with back-to-back pops.
   task automatic test_full_drain;
      int cnt;
      logic [AW-1:0] exp_a;
      do_reset();
      wptr = 5'b11000;
      for (int i = 0; i < 16; i++) sb_q.push_back(AW'(i));
      repeat (3) tick();
      checks++; if (rcount !== 5'd16) begin errs++; $display("FAIL fd_rcount got=%0d exp=16", rcount); end
      checks++; if (ralmost_empty !== 1'b0 || rempty !== 1'b0) begin errs++; $display("FAIL fd_flags got=%b/%b exp=0/0", ralmost_empty, rempty); end
      for (int i = 1; i <= 16; i++) begin
         rinc  = 1'b1;
         exp_a = sb_q.pop_front();
         checks++; if (raddr !== exp_a) begin errs++; $display("FAIL fd_raddr got=%0d exp=%0d", raddr, exp_a); end
         tick();
         cnt = 16 - i;
         checks++; if (rcount !== PW'(cnt)) begin errs++; $display("FAIL fd_count got=%0d exp=%0d", rcount, cnt); end
         checks++; if (ralmost_empty !== (cnt <= TH)) begin errs++; $display("FAIL fd_raempty got=%b exp=%b at %0d", ralmost_empty, (cnt <= TH), cnt); end
         checks++; if (rempty !== (cnt == 0)) begin errs++; $display("FAIL fd_rempty got=%b exp=%b at %0d", rempty, (cnt == 0), cnt); end
      end
      rinc = 1'b0;
      checks++; if (rptr !== 5'b11000) begin errs++; $display("FAIL fd_rptr got=%b exp=11000", rptr); end
      checks++; if (raddr !== '0) begin errs++; $display("FAIL fd_raddr_wrap got=%0d exp=0", raddr); end
   endtask

   // Random write/read stream of 40 entries; the read pointer wraps past 31.
   task automatic test_stream;
      int wcnt, rd, cyc;
      logic [AW-1:0] exp_a;
      do_reset();
      wcnt = 0; rd = 0; cyc = 0;
      while (rd < 40 && cyc < 2000) begin
         checks++; if ((rcount == '0) !== rempty) begin errs++; $display("FAIL st_inv rcount=%0d rempty=%b", rcount, rempty); end
         checks++; if (runderflow !== 1'b0) begin errs++; $display("FAIL st_underflow got=%b exp=0", runderflow); end
         if (wcnt < 40 && (wcnt - rd) < 16 && $urandom_range(0, 3) != 0) begin
            sb_q.push_back(AW'(wcnt));
            wcnt++;
            wptr = gray(PW'(wcnt));
         end
         if (!rempty && $urandom_range(0, 2) != 0) begin
            rinc = 1'b1;
            checks++;
            if (sb_q.size() == 0) begin
               errs++; $display("FAIL st_early_nonempty got=rempty0 exp=rempty1");
            end else begin
               exp_a = sb_q.pop_front();
               if (raddr !== exp_a) begin errs++; $display("FAIL st_raddr got=%0d exp=%0d", raddr, exp_a); end
            end
            rd++;
         end else begin
            rinc = 1'b0;
         end
         tick();
         cyc++;
      end
      rinc = 1'b0;
      checks++; if (cyc >= 2000) begin errs++; $display("FAIL st_timeout got=%0d exp=40 reads", rd); end
      checks++; if (rptr !== 5'b01100) begin errs++; $display("FAIL st_rptr got=%b exp=01100", rptr); end
      repeat (3) tick();
      checks++; if (rempty !== 1'b1 || rcount !== '0) begin errs++; $display("FAIL st_final got=%b/%0d exp=1/0", rempty, rcount); end
   endtask

   // Pop on the same edge the synchronized write pointer advances.
   task automatic test_back_to_back;
      do_reset();
      wptr = gray(5'd2);
      repeat (3) tick();
      checks++; if (rcount !== 5'd2) begin errs++; $display("FAIL bb_pre got=%0d exp=2", rcount); end
      wptr = gray(5'd3);
      tick(); // rq1 has 3
      rinc = 1'b1;
      checks++; if (raddr !== 4'd0) begin errs++; $display("FAIL bb_raddr got=%0d exp=0", raddr); end
      tick(); // rq2 -> 3 and pop on this edge; flags use old rq2 (2)
      rinc = 1'b0;
      checks++; if (rptr !== gray(5'd1)) begin errs++; $display("FAIL bb_rptr got=%b exp=%b", rptr, gray(5'd1)); end
      checks++; if (rcount !== 5'd1) begin errs++; $display("FAIL bb_count1 got=%0d exp=1", rcount); end
      tick();
      checks++; if (rcount !== 5'd2 || raddr !== 4'd1) begin errs++; $display("FAIL bb_count2 got=%0d/%0d exp=2/1", rcount, raddr); end
   endtask

   initial begin
      rrst_n = 1'b0;
      rinc   = 1'b0;
      wptr   = '0;
      #12;
      checks++; if (rempty !== 1'b1 || rcount !== '0 || rptr !== '0) begin errs++; $display("FAIL por got=%b/%0d/%b exp=1/0/0", rempty, rcount, rptr); end
      rrst_n = 1'b1;
      test_reset();
      test_latency();
      test_underflow();
      test_full_drain();
      test_stream();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
